// File: rtl/mem_copy_master.sv
// ----------------------------------------------------------------------------
// mem_copy_master
//   Bus initiator that copies a block of 32-bit words from one data-memory
//   region to another. It shares the core's single-port SRAM interface
//   (one-cycle synchronous read) behind an external arbiter.
//
//   Each word takes three states: RD issues the read, CAP captures dout,
//   and WR writes the word. RD and WR stall while grant_i is low. CAP
//   proceeds regardless of grant_i.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               start pulse, sampled only in IDLE
//   src_addr_i/dst_addr_i source/destination byte addresses
//   len_i                 number of words to copy
//   abort_i               stop the transfer
//   grant_i               arbiter grant for the SRAM port
//   busy_o, done_o        transfer in progress / one-cycle completion pulse
//   err_o                 misalignment flag, held until the next start
//   words_o               words written in the current or last transfer
//   mem_*                 SRAM port: csb/web active-low, wmask, word address,
//                         write data, read data
// ----------------------------------------------------------------------------
module mem_copy_master #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [31:0]       src_addr_i,
  input  logic [31:0]       dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  input  logic              grant_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_o,
  output logic              mem_csb_o,
  output logic              mem_web_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       w_src_nxt;
  logic [31:0]       w_dst_nxt;
  logic              w_misaligned;
  logic              w_wr_fire;

  assign w_src_nxt    = r_src + 32'd4;
  assign w_dst_nxt    = r_dst + 32'd4;
  assign w_misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
  assign w_wr_fire    = (r_state == S_WR) && grant_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort_i overrides the normal successor outside IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_misaligned || (len_i == '0)) begin
            w_next = S_FIN;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD: begin
        if (abort_i) begin
          w_next = S_FIN;
        end else if (grant_i) begin
          w_next = S_CAP;
        end
      end
      S_CAP: begin
        if (abort_i) begin
          w_next = S_FIN;
        end else begin
          w_next = S_WR;
        end
      end
      S_WR: begin
        if (abort_i) begin
          w_next = S_FIN;
        end else if (grant_i) begin
          w_next = (r_rem > LEN_ONE) ? S_RD : S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus strobes are the only combinational outputs: asserted only when the
  // arbiter grants the port in an access state.
  always_comb begin
    mem_csb_o = 1'b1;
    mem_web_o = 1'b1;
    case (r_state)
      S_RD: mem_csb_o = !grant_i;
      S_WR: begin
        mem_csb_o = !grant_i;
        mem_web_o = !grant_i;
      end
      default: begin
        mem_csb_o = 1'b1;
        mem_web_o = 1'b1;
      end
    endcase
  end

  // Registered datapath and status outputs. mem_addr_o is loaded on the edge
  // entering RD/WR so the address is already valid during the access cycle;
  // mem_data_o doubles as the captured read word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_rem       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
      mem_wmask_o <= 4'hF;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else begin
      mem_wmask_o <= 4'hF;
      done_o      <= (r_state == S_FIN);
      busy_o      <= (w_next != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_src      <= src_addr_i;
            r_dst      <= dst_addr_i;
            r_rem      <= len_i;
            words_o    <= '0;
            err_o      <= w_misaligned;
            mem_addr_o <= src_addr_i[ADDR_W+1:2];
          end
        end
        S_CAP: begin
          mem_data_o <= mem_data_i;
          mem_addr_o <= r_dst[ADDR_W+1:2];
        end
        S_WR: begin
          if (w_wr_fire) begin
            r_src      <= w_src_nxt;
            r_dst      <= w_dst_nxt;
            r_rem      <= r_rem - LEN_ONE;
            words_o    <= words_o + LEN_ONE;
            mem_addr_o <= w_src_nxt[ADDR_W+1:2];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
